// File: rtl/maxpool_scan_pkg.sv
// Shared widths, FSM encoding and output-dimension helper for the max-pool
// scanner and its pick stage.
package maxpool_scan_pkg;

  localparam int MP_IDX_W     = 4;
  localparam int MP_RES_IDX_W = 8;

  typedef enum logic {
    MP_IDLE = 1'b0,
    MP_SCAN = 1'b1
  } mp_state_t;

  function automatic int mp_out_dim(input int din, input int k, input int pad, input int s);
    return ((din - k + 2 * pad) / s) + 1;
  endfunction

endpackage

// File: rtl/maxpool_scan_win_cnt.sv
// Nested window counters: kx fastest, then ky, then ox, then oy.
// Flags describe the position currently held, before the advance.
module maxpool_win_cnt
  import maxpool_scan_pkg::*;
#(
  parameter int KW = 2,
  parameter int KH = 2,
  parameter int OW = 2,
  parameter int OH = 2
) (
  input  logic                clk_en,
  input  logic                reset_n,
  input  logic                i_clear,
  input  logic                i_adv,
  output logic [MP_IDX_W-1:0] o_kx,
  output logic [MP_IDX_W-1:0] o_ky,
  output logic [MP_IDX_W-1:0] o_ox,
  output logic [MP_IDX_W-1:0] o_oy,
  output logic                o_win_first,
  output logic                o_win_last,
  output logic                o_pass_last
);

  logic [MP_IDX_W-1:0] r_kx;
  logic [MP_IDX_W-1:0] r_ky;
  logic [MP_IDX_W-1:0] r_ox;
  logic [MP_IDX_W-1:0] r_oy;
  logic                w_kx_last;
  logic                w_ky_last;
  logic                w_ox_last;
  logic                w_oy_last;

  assign w_kx_last = (r_kx == MP_IDX_W'(KW - 1));
  assign w_ky_last = (r_ky == MP_IDX_W'(KH - 1));
  assign w_ox_last = (r_ox == MP_IDX_W'(OW - 1));
  assign w_oy_last = (r_oy == MP_IDX_W'(OH - 1));

  always_ff @(posedge clk_en) begin
    if (!reset_n || i_clear) begin
      r_kx <= '0;
      r_ky <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_adv) begin
      if (!w_kx_last) begin
        r_kx <= r_kx + 1'b1;
      end else begin
        r_kx <= '0;
        if (!w_ky_last) begin
          r_ky <= r_ky + 1'b1;
        end else begin
          r_ky <= '0;
          if (!w_ox_last) begin
            r_ox <= r_ox + 1'b1;
          end else begin
            r_ox <= '0;
            r_oy <= w_oy_last ? '0 : r_oy + 1'b1;
          end
        end
      end
    end
  end

  assign o_kx        = r_kx;
  assign o_ky        = r_ky;
  assign o_ox        = r_ox;
  assign o_oy        = r_oy;
  assign o_win_first = (r_kx == '0) && (r_ky == '0);
  assign o_win_last  = w_kx_last && w_ky_last;
  assign o_pass_last = w_kx_last && w_ky_last && w_ox_last && w_oy_last;

endmodule

// File: rtl/maxpool_scan.sv
// Max-pool sequencer: issues registered pick indices one window element per cycle,
// folds the returned elements into a running max and stores one result per window.
module maxpool_scan
  import maxpool_scan_pkg::*;
#(
  parameter int datai_width   = 4,
  parameter int datai_height  = 4,
  parameter int kernel_width  = 2,
  parameter int kernel_height = 2,
  parameter int stride        = 2,
  parameter int padding       = 0,
  parameter int datao_width   = mp_out_dim(datai_width, kernel_width, padding, stride),
  parameter int datao_height  = mp_out_dim(datai_height, kernel_height, padding, stride),
  parameter int bitwidth      = 3
) (
  input  logic                                        clk_en,
  input  logic                                        reset_n,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        pick_on,
  output logic [MP_IDX_W-1:0]                         pick_l,
  output logic [MP_IDX_W-1:0]                         pick_c,
  input  logic [bitwidth-1:0]                         pick_data,
  output logic                                        res_valid,
  output logic [MP_RES_IDX_W-1:0]                     res_idx,
  output logic [bitwidth-1:0]                         res_data,
  output logic [datao_width*datao_height*bitwidth-1:0] data_o
);

  localparam int NOUT = datao_width * datao_height;

  if ((datai_height + 2 * padding > 16) || (datai_width + 2 * padding > 16) ||
      (NOUT > 256)) begin : g_cfg_bad
    $error("maxpool_scan: configuration exceeds index widths");
  end

  mp_state_t                   r_state;
  mp_state_t                   w_state_next;
  logic                        w_busy;
  logic                        w_start_acc;
  logic                        w_issue;
  logic                        w_fin;
  logic                        r_issued_all;
  logic                        r_smp_vld;
  logic                        r_smp_first;
  logic                        r_smp_last;
  logic                        r_smp_pass_last;
  logic [MP_RES_IDX_W-1:0]     r_smp_slot;
  logic [bitwidth-1:0]         r_max;
  logic [bitwidth-1:0]         w_max_new;
  logic [MP_IDX_W-1:0]         r_pick_l;
  logic [MP_IDX_W-1:0]         r_pick_c;
  logic                        r_done;
  logic                        r_res_valid;
  logic [MP_RES_IDX_W-1:0]     r_res_idx;
  logic [bitwidth-1:0]         r_res_data;
  logic [NOUT*bitwidth-1:0]    r_data_o;
  logic [MP_IDX_W-1:0]         w_kx;
  logic [MP_IDX_W-1:0]         w_ky;
  logic [MP_IDX_W-1:0]         w_ox;
  logic [MP_IDX_W-1:0]         w_oy;
  logic                        w_win_first;
  logic                        w_win_last;
  logic                        w_pass_last;
  logic [MP_IDX_W-1:0]         w_l;
  logic [MP_IDX_W-1:0]         w_c;
  logic [MP_RES_IDX_W-1:0]     w_slot;

  assign w_start_acc = (r_state == MP_IDLE) && start;
  assign w_issue     = (r_state == MP_SCAN) && !r_issued_all;
  assign w_fin       = r_smp_vld && r_smp_pass_last;

  maxpool_win_cnt #(
    .KW (kernel_width),
    .KH (kernel_height),
    .OW (datao_width),
    .OH (datao_height)
  ) u_win_cnt (
    .clk_en      (clk_en),
    .reset_n     (reset_n),
    .i_clear     (w_start_acc),
    .i_adv       (w_issue),
    .o_kx        (w_kx),
    .o_ky        (w_ky),
    .o_ox        (w_ox),
    .o_oy        (w_oy),
    .o_win_first (w_win_first),
    .o_win_last  (w_win_last),
    .o_pass_last (w_pass_last)
  );

  assign w_l    = MP_IDX_W'(int'(w_oy) * stride + int'(w_ky));
  assign w_c    = MP_IDX_W'(int'(w_ox) * stride + int'(w_kx));
  assign w_slot = MP_RES_IDX_W'(w_oy) * MP_RES_IDX_W'(datao_width) + MP_RES_IDX_W'(w_ox);

  always_ff @(posedge clk_en) begin
    if (!reset_n) r_state <= MP_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      MP_IDLE: if (start) w_state_next = MP_SCAN;
      MP_SCAN: begin
        w_busy = 1'b1;
        if (w_fin) w_state_next = MP_IDLE;
      end
      default: w_state_next = MP_IDLE;
    endcase
  end

  // Indices lead the sample by one cycle, so window flags travel with them.
  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      r_issued_all    <= 1'b0;
      r_smp_vld       <= 1'b0;
      r_smp_first     <= 1'b0;
      r_smp_last      <= 1'b0;
      r_smp_pass_last <= 1'b0;
      r_smp_slot      <= '0;
      r_pick_l        <= '0;
      r_pick_c        <= '0;
    end else begin
      if (w_start_acc)                 r_issued_all <= 1'b0;
      else if (w_issue && w_pass_last) r_issued_all <= 1'b1;
      r_smp_vld <= w_issue;
      if (w_issue) begin
        r_smp_first     <= w_win_first;
        r_smp_last      <= w_win_last;
        r_smp_pass_last <= w_pass_last;
        r_smp_slot      <= w_slot;
        r_pick_l        <= w_l;
        r_pick_c        <= w_c;
      end else begin
        r_pick_l <= '0;
        r_pick_c <= '0;
      end
    end
  end

  assign w_max_new = (r_smp_first || (pick_data > r_max)) ? pick_data : r_max;

  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      r_max       <= '0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
    end else begin
      r_done      <= w_fin;
      r_res_valid <= r_smp_vld && r_smp_last;
      if (r_smp_vld) r_max <= w_max_new;
      if (r_smp_vld && r_smp_last) begin
        r_res_idx  <= r_smp_slot;
        r_res_data <= w_max_new;
      end
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_slot
    always_ff @(posedge clk_en) begin
      if (!reset_n)
        r_data_o[gi*bitwidth +: bitwidth] <= '0;
      else if (r_smp_vld && r_smp_last && (r_smp_slot == MP_RES_IDX_W'(gi)))
        r_data_o[gi*bitwidth +: bitwidth] <= w_max_new;
    end
  end

  assign busy      = w_busy;
  assign pick_on   = w_busy;
  assign pick_l    = r_pick_l;
  assign pick_c    = r_pick_c;
  assign done      = r_done;
  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_data  = r_res_data;
  assign data_o    = r_data_o;

endmodule

// File: tb/tb_maxpool_scan.sv
// Directed bench for maxpool_scan: default 4x4/2x2/stride-2 instance plus a padding=1
// instance, both fed by a behavioural pick stage over one shared 4x4 map.
module tb_maxpool_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic        start_p;
  logic [47:0] map_v;

  logic        busy, done, pick_on, res_valid;
  logic [3:0]  pick_l, pick_c;
  logic [2:0]  pick_data, res_data;
  logic [7:0]  res_idx;
  logic [11:0] data_o;

  logic        busy_p, done_p, pick_on_p, res_valid_p;
  logic [3:0]  pick_l_p, pick_c_p;
  logic [2:0]  pick_data_p, res_data_p;
  logic [7:0]  res_idx_p;
  logic [26:0] data_o_p;

  int total = 0;
  int bad   = 0;

  function automatic logic [2:0] pick_model(input logic [47:0] mv, input logic [3:0] l,
                                            input logic [3:0] c, input int pad);
    int r, k;
    r = int'(l) - pad;
    k = int'(c) - pad;
    if (r < 0 || r > 3 || k < 0 || k > 3) return 3'd0;
    return mv[(r*4+k)*3 +: 3];
  endfunction

  assign pick_data   = pick_model(map_v, pick_l, pick_c, 0);
  assign pick_data_p = pick_model(map_v, pick_l_p, pick_c_p, 1);

  maxpool_scan u_dut (
    .clk_en(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pick_on(pick_on), .pick_l(pick_l), .pick_c(pick_c), .pick_data(pick_data),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .data_o(data_o)
  );

  maxpool_scan #(.padding(1)) u_dut_p (
    .clk_en(clk), .reset_n(reset_n), .start(start_p), .busy(busy_p), .done(done_p),
    .pick_on(pick_on_p), .pick_l(pick_l_p), .pick_c(pick_c_p), .pick_data(pick_data_p),
    .res_valid(res_valid_p), .res_idx(res_idx_p), .res_data(res_data_p), .data_o(data_o_p)
  );

  int         cyc, nres, max_l, busy_cnt;
  logic [7:0] got_idx [0:15];
  logic [2:0] got_dat [0:15];
  logic [7:0] trace   [0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_map(input int v [16]);
    for (int i = 0; i < 16; i++) map_v[i*3 +: 3] = 3'(v[i]);
  endtask

  // Pulses start on one instance, then logs results and indices until done.
  task automatic run_pass(input bit pad_dut);
    nres = 0; cyc = 0; max_l = 0; busy_cnt = 0;
    if (pad_dut) start_p = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start_p = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      cyc = n;
      if (pad_dut) begin
        if (int'(pick_l_p) > max_l) max_l = int'(pick_l_p);
        if (res_valid_p && nres < 16) begin
          got_idx[nres] = res_idx_p; got_dat[nres] = res_data_p; nres++;
        end
        if (done_p) break;
      end else begin
        if (n < 64) trace[n] = {pick_l, pick_c};
        if (busy && pick_on) busy_cnt++;
        if (res_valid && nres < 16) begin
          got_idx[nres] = res_idx; got_dat[nres] = res_data; nres++;
        end
        if (done) break;
      end
    end
  endtask

  logic [7:0]  exp_tr  [16];
  logic [2:0]  exp_r1  [4];
  logic [2:0]  exp_p   [9];
  logic [26:0] exp_dp;
  int          ndone;

  initial begin
    exp_tr = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h02, 8'h03, 8'h12, 8'h13,
               8'h20, 8'h21, 8'h30, 8'h31, 8'h22, 8'h23, 8'h32, 8'h33};
    exp_r1 = '{3'd6, 3'd7, 3'd7, 3'd3};
    exp_p  = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1, 3'd2, 3'd7, 3'd3};

    reset_n = 1'b0; start = 1'b0; start_p = 1'b0; map_v = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pick_on", pick_on, 0);
    chk("rst_pick_lc", {pick_l, pick_c}, 0);
    chk("rst_res", {res_valid, res_idx, res_data}, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_data_o_p", data_o_p, 0);
    reset_n = 1'b1;
    tick();

    // Main map
    load_map('{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 1, 1, 2, 7, 3, 3});
    run_pass(0);
    chk("m1_latency", cyc, 17);
    chk("m1_nres", nres, 4);
    chk("m1_busy_cycles", busy_cnt, 16);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m1_idx%0d", k), got_idx[k], k);
      chk($sformatf("m1_dat%0d", k), got_dat[k], exp_r1[k]);
    end
    chk("m1_data_o", data_o, 12'b011_111_111_110);
    for (int n = 1; n <= 16; n++) chk($sformatf("m1_trace%0d", n), trace[n], exp_tr[n-1]);
    chk("m1_done_busy", busy, 0);
    chk("m1_done_pick", {pick_l, pick_c}, 0);
    tick();
    chk("m1_done_pulse", done, 0);

    // All-equal map
    load_map('{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5});
    run_pass(0);
    chk("tie_nres", nres, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("tie_dat%0d", k), got_dat[k], 5);
    chk("tie_data_o", data_o, 12'b101_101_101_101);

    // Single maximum in the bottom-right corner
    load_map('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7});
    run_pass(0);
    chk("corner_data_o", data_o, 12'b111_000_000_000);

    // Reset during a scan
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_pick_on", pick_on, 0);
    chk("mid_data_o", data_o, 0);
    chk("mid_pick_lc", {pick_l, pick_c}, 0);
    chk("mid_res_valid", res_valid, 0);
    reset_n = 1'b1;
    tick();
    load_map('{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 1, 1, 2, 7, 3, 3});
    run_pass(0);
    chk("mid_rerun_latency", cyc, 17);
    chk("mid_rerun_nres", nres, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("mid_rerun_dat%0d", k), got_dat[k], exp_r1[k]);
    chk("mid_rerun_data_o", data_o, 12'b011_111_111_110);

    // start held high across a whole pass
    ndone = 0;
    start = 1'b1;
    tick();
    for (int n = 1; n <= 18; n++) begin
      tick();
      if (done) ndone++;
      if (n == 17) chk("hold_done_at_17", done, 1);
      if (n == 18) chk("hold_second_pass_busy", busy, 1);
    end
    chk("hold_done_count", ndone, 1);
    start = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Padding = 1 instance
    run_pass(1);
    chk("pad_latency", cyc, 37);
    chk("pad_nres", nres, 9);
    chk("pad_max_l", max_l, 5);
    exp_dp = '0;
    for (int k = 0; k < 9; k++) begin
      exp_dp[k*3 +: 3] = exp_p[k];
      chk($sformatf("pad_idx%0d", k), got_idx[k], k);
      chk($sformatf("pad_dat%0d", k), got_dat[k], exp_p[k]);
    end
    chk("pad_data_o", data_o_p, exp_dp);
    chk("pad_default_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
